// File: rtl/regs_wr_arbiter_if.sv
// rtl/regs_wr_arbiter_if.sv - bus bundle between the GPR write arbiter and its producers/register file
//
// Purpose: groups every non-clock/reset signal of regs_wr_arbiter.
//   master : producer/consumer side (drives wb_*, lu_*, dbg_* requests; sees acks and rf_* writes)
//   slave  : the arbiter itself
// Signals:
//   wb_we/wb_addr/wb_data        pipeline writeback
//   lu_valid/lu_addr/lu_data     long-latency result offer, lu_ready accept
//   dbg_valid/dbg_addr/dbg_data  debugger request, dbg_ready ack
//   rf_we/rf_addr/rf_data        register file write port
//   pending                      per-register mask of live queued lu writes
//   stall_req                    registered request for the pipeline to hold wb
interface regs_wr_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        dbg_valid;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        dbg_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] pending;
    logic        stall_req;

    modport master (
        output wb_we, wb_addr, wb_data,
        output lu_valid, lu_addr, lu_data,
        output dbg_valid, dbg_addr, dbg_data,
        input  lu_ready, dbg_ready,
        input  rf_we, rf_addr, rf_data, pending, stall_req
    );

    modport slave (
        input  wb_we, wb_addr, wb_data,
        input  lu_valid, lu_addr, lu_data,
        input  dbg_valid, dbg_addr, dbg_data,
        output lu_ready, dbg_ready,
        output rf_we, rf_addr, rf_data, pending, stall_req
    );
endinterface

// File: rtl/regs_wr_arbiter.sv
// rtl/regs_wr_arbiter.sv - arbitrates the single GPR write port among wb, lu queue and debugger
//
// Purpose: wb always wins with zero latency; otherwise the live head of an
// ordered lu queue, then the debugger. Queued lu writes overtaken by a wb
// write to the same register are killed so the register file never sees a
// stale lu value. A registered stall request is raised when head/dbg are
// starved for STARVE_MAX consecutive cycles.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous reset, active-high
//   bus  : regs_wr_arbiter_if.slave (wb_*, lu_*, dbg_*, rf_*, pending, stall_req)
module regs_wr_arbiter #(
    parameter int LU_DEPTH   = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    regs_wr_arbiter_if.slave     bus
);
    localparam int AW = $clog2(LU_DEPTH);
    localparam int SW = $clog2(STARVE_MAX);

    logic [AW-1:0]       r_wp;
    logic [AW-1:0]       r_rp;
    logic [AW:0]         r_count;
    logic [4:0]          r_addr [LU_DEPTH];
    logic [31:0]         r_data [LU_DEPTH];
    logic [LU_DEPTH-1:0] r_live;
    logic [SW-1:0]       r_starve_cnt;
    logic                r_stall;

    logic                w_wb_act;
    logic                w_empty;
    logic                w_full;
    logic [LU_DEPTH-1:0] w_live_pk;
    logic                w_head_live;
    logic                w_head_grant;
    logic                w_dbg_req;
    logic                w_dbg_grant;
    logic                w_dbg_drop;
    logic                w_pop;
    logic                w_push;
    logic                w_push_live;
    logic                w_starved;
    logic [31:0]         w_pending;

    always_comb begin
        w_wb_act = !rst && bus.wb_we && (bus.wb_addr != 5'd0);
        w_empty  = (r_count == '0);
        w_full   = (r_count == (AW+1)'(LU_DEPTH));

        // Live bits after this cycle's wb kill; slots not occupied always hold live=0.
        for (int i = 0; i < LU_DEPTH; i++) begin
            w_live_pk[i] = r_live[i] && !(w_wb_act && (r_addr[i] == bus.wb_addr));
        end

        w_head_live  = !rst && !w_empty && w_live_pk[r_rp];
        w_head_grant = !w_wb_act && w_head_live;
        w_dbg_req    = !rst && bus.dbg_valid && (bus.dbg_addr != 5'd0);
        w_dbg_grant  = !w_wb_act && !w_head_live && w_dbg_req;
        w_dbg_drop   = !rst && bus.dbg_valid && (bus.dbg_addr == 5'd0);

        // A non-empty queue pops either a granted head or a dead (possibly just killed) head.
        w_pop       = !rst && !w_empty && (w_head_grant || !w_head_live);
        w_push      = !rst && bus.lu_valid && !w_full;
        // Queued lu writes are older than a concurrent wb, so a same-cycle match enqueues dead.
        w_push_live = (bus.lu_addr != 5'd0) && !(w_wb_act && (bus.lu_addr == bus.wb_addr));

        w_starved = (w_head_live || w_dbg_req) && !w_head_grant && !w_dbg_grant;

        w_pending = '0;
        for (int i = 0; i < LU_DEPTH; i++) begin
            if (w_live_pk[i]) begin
                w_pending = w_pending | (32'd1 << r_addr[i]);
            end
        end
    end

    assign bus.lu_ready  = !rst && !w_full;
    assign bus.dbg_ready = w_dbg_grant || w_dbg_drop;
    assign bus.rf_we     = w_wb_act || w_head_grant || w_dbg_grant;
    assign bus.rf_addr   = w_wb_act     ? bus.wb_addr  :
                           w_head_grant ? r_addr[r_rp] :
                           w_dbg_grant  ? bus.dbg_addr : 5'd0;
    assign bus.rf_data   = w_wb_act     ? bus.wb_data  :
                           w_head_grant ? r_data[r_rp] :
                           w_dbg_grant  ? bus.dbg_data : 32'd0;
    assign bus.pending   = rst ? 32'd0 : w_pending;
    assign bus.stall_req = r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            r_live       <= '0;
            r_starve_cnt <= '0;
            r_stall      <= 1'b0;
        end else begin
            r_live <= w_live_pk;
            if (w_pop) begin
                r_live[r_rp] <= 1'b0;
                r_rp         <= r_rp + AW'(1);
            end
            if (w_push) begin
                r_addr[r_wp] <= bus.lu_addr;
                r_data[r_wp] <= bus.lu_data;
                r_live[r_wp] <= w_push_live;
                r_wp         <= r_wp + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

            // Counter saturates at STARVE_MAX-1; stall holds through idle cycles until a head/dbg grant.
            if (w_starved) begin
                if (r_starve_cnt == SW'(STARVE_MAX - 1)) begin
                    r_stall <= 1'b1;
                end else begin
                    r_starve_cnt <= r_starve_cnt + SW'(1);
                end
            end else begin
                r_starve_cnt <= '0;
            end
            if (w_head_grant || w_dbg_grant) begin
                r_stall <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regs_wr_arbiter.sv
// tb/tb_regs_wr_arbiter.sv - self-checking bench for regs_wr_arbiter
module tb_regs_wr_arbiter;
    localparam int LU_DEPTH   = 4;
    localparam int STARVE_MAX = 8;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          live;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regs_wr_arbiter_if bus ();

    regs_wr_arbiter #(.LU_DEPTH(LU_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    bit          en = 1'b0;
    ent_t        m_q[$];
    int          m_run = 0;
    bit          m_stall = 1'b0;
    logic [31:0] tb_rf [32];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    // Reference model: ordered list of queued lu writes, evaluated once per cycle.
    task automatic model_step;
        bit          wb, head_live, other, starved, e_we, e_lur, e_dbr;
        logic [4:0]  e_a;
        logic [31:0] e_d, pend;
        wb = bus.wb_we && (bus.wb_addr != 5'd0);
        foreach (m_q[i]) if (wb && m_q[i].a == bus.wb_addr) m_q[i].live = 1'b0;
        pend = '0;
        foreach (m_q[i]) if (m_q[i].live) pend[m_q[i].a] = 1'b1;
        e_lur = (m_q.size() < LU_DEPTH);
        e_we = 0; e_a = '0; e_d = '0; other = 0; e_dbr = 0;
        head_live = (m_q.size() > 0) && m_q[0].live;
        if (wb) begin
            e_we = 1; e_a = bus.wb_addr; e_d = bus.wb_data;
        end
        if (m_q.size() > 0) begin
            if (!m_q[0].live) begin
                void'(m_q.pop_front());
            end else if (!wb) begin
                e_we = 1; e_a = m_q[0].a; e_d = m_q[0].d; other = 1;
                void'(m_q.pop_front());
            end
        end
        if (!wb && !other && bus.dbg_valid && bus.dbg_addr != 5'd0) begin
            e_we = 1; e_a = bus.dbg_addr; e_d = bus.dbg_data; other = 1; e_dbr = 1;
        end
        if (bus.dbg_valid && bus.dbg_addr == 5'd0) e_dbr = 1;
        starved = (head_live || (bus.dbg_valid && bus.dbg_addr != 5'd0)) && !other;

        chk("m_rf_we", 32'(bus.rf_we), 32'(e_we));
        if (e_we) begin
            chk("m_rf_addr", 32'(bus.rf_addr), 32'(e_a));
            chk("m_rf_data", bus.rf_data, e_d);
        end
        chk("m_lu_ready", 32'(bus.lu_ready), 32'(e_lur));
        chk("m_dbg_ready", 32'(bus.dbg_ready), 32'(e_dbr));
        chk("m_pending", bus.pending, pend);
        chk("m_stall_req", 32'(bus.stall_req), 32'(m_stall));

        if (starved) begin
            m_run++;
            if (m_run >= STARVE_MAX) m_stall = 1'b1;
        end else begin
            m_run = 0;
        end
        if (other) m_stall = 1'b0;
        if (bus.lu_valid && e_lur)
            m_q.push_back('{a: bus.lu_addr, d: bus.lu_data,
                            live: (bus.lu_addr != 5'd0) && !(wb && bus.lu_addr == bus.wb_addr)});
        if (bus.rf_we) tb_rf[bus.rf_addr] = bus.rf_data;
    endtask

    always @(negedge clk) begin
        if (en) model_step();
    end

    task automatic setin(input bit we, input int wa, input logic [31:0] wd,
                         input bit lv, input int la, input logic [31:0] ld,
                         input bit dv, input int da, input logic [31:0] dd);
        bus.wb_we = we;     bus.wb_addr = 5'(wa);  bus.wb_data = wd;
        bus.lu_valid = lv;  bus.lu_addr = 5'(la);  bus.lu_data = ld;
        bus.dbg_valid = dv; bus.dbg_addr = 5'(da); bus.dbg_data = dd;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0]  da;
        logic [31:0] dd;
        da = 5'd3;
        dd = 32'hD000;
        foreach (tb_rf[i]) tb_rf[i] = '0;

        // Reset with requests asserted
        rst = 1'b1;
        setin(0, 0, 0, 1, 3, 32'h33, 1, 3, 32'h33);
        smp; nxt;
        smp;
        chk("rst_rf_we", 32'(bus.rf_we), 0);
        chk("rst_lu_ready", 32'(bus.lu_ready), 0);
        chk("rst_dbg_ready", 32'(bus.dbg_ready), 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_stall_req", 32'(bus.stall_req), 0);
        nxt;
        rst = 1'b0;
        en = 1'b1;

        // wb pass-through
        setin(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        smp;
        chk("wb_rf_we", 32'(bus.rf_we), 1);
        chk("wb_rf_addr", 32'(bus.rf_addr), 5);
        chk("wb_rf_data", bus.rf_data, 32'hDEADBEEF);
        nxt;
        setin(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0);
        smp;
        chk("wb_r0_rf_we", 32'(bus.rf_we), 0);
        nxt;

        // Queue fill while wb busy, then drain
        for (int k = 1; k <= 5; k++) begin
            setin(1, 20, 32'(k), 1, k, 32'(100 + k), 0, 0, 0);
            smp;
            if (k == 5) begin
                chk("fill_lu_ready_full", 32'(bus.lu_ready), 0);
                chk("fill_pending", bus.pending, 32'h1E);
            end else begin
                chk("fill_lu_ready", 32'(bus.lu_ready), 1);
            end
            nxt;
        end
        setin(0, 0, 0, 1, 5, 32'd105, 0, 0, 0);
        smp;
        chk("drain_r1", 32'(bus.rf_addr), 1);
        chk("drain_ready_prepop", 32'(bus.lu_ready), 0);
        nxt;
        smp;
        chk("drain_r2", 32'(bus.rf_addr), 2);
        chk("drain_ready", 32'(bus.lu_ready), 1);
        nxt;
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
        smp; chk("drain_r3", 32'(bus.rf_addr), 3); nxt;
        smp; chk("drain_r4", 32'(bus.rf_addr), 4); nxt;
        smp;
        chk("drain_r5", 32'(bus.rf_addr), 5);
        chk("drain_r5_data", bus.rf_data, 32'd105);
        nxt;
        smp;
        chk("drain_idle_we", 32'(bus.rf_we), 0);
        chk("drain_pending", bus.pending, 0);
        nxt;

        // Kill by later wb, and same-cycle lu/wb to one register
        setin(0, 0, 0, 1, 7, 32'h11, 0, 0, 0);
        smp; chk("kill_enq_pending", bus.pending, 0); nxt;
        setin(1, 7, 32'h22, 0, 0, 0, 0, 0, 0);
        smp;
        chk("kill_pending", bus.pending, 0);
        chk("kill_wb_data", bus.rf_data, 32'h22);
        nxt;
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
        smp; chk("kill_no_r7", 32'(bus.rf_we), 0); nxt;
        setin(1, 9, 32'h98, 1, 9, 32'h99, 0, 0, 0);
        smp; chk("same_wb_data", bus.rf_data, 32'h98); nxt;
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
        smp;
        chk("same_no_lu", 32'(bus.rf_we), 0);
        chk("same_pending", bus.pending, 0);
        nxt;
        smp;
        chk("final_r7", tb_rf[7], 32'h22);
        chk("final_r9", tb_rf[9], 32'h98);
        nxt;

        // Priority head over dbg, dbg ack, addr-0 dbg ack
        setin(1, 20, 32'hAA, 1, 6, 32'h66, 1, 3, 32'h33);
        smp; chk("prio_wb_first", 32'(bus.rf_addr), 20); chk("prio_dbg_wait", 32'(bus.dbg_ready), 0); nxt;
        setin(0, 0, 0, 0, 0, 0, 1, 3, 32'h33);
        smp; chk("prio_head", 32'(bus.rf_addr), 6); chk("prio_dbg_wait2", 32'(bus.dbg_ready), 0); nxt;
        smp;
        chk("prio_dbg_addr", 32'(bus.rf_addr), 3);
        chk("prio_dbg_data", bus.rf_data, 32'h33);
        chk("prio_dbg_ready", 32'(bus.dbg_ready), 1);
        nxt;
        setin(0, 0, 0, 0, 0, 0, 1, 0, 32'h55);
        smp; chk("dbg0_ready", 32'(bus.dbg_ready), 1); chk("dbg0_no_we", 32'(bus.rf_we), 0); nxt;
        setin(1, 12, 32'h77, 0, 0, 0, 1, 0, 0);
        smp; chk("dbg0_wb_ready", 32'(bus.dbg_ready), 1); chk("dbg0_wb_addr", 32'(bus.rf_addr), 12); nxt;

        // Dead entry (lu addr 0) never written
        setin(0, 0, 0, 1, 0, 32'hEE, 0, 0, 0);
        smp; nxt;
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
        smp; chk("dead_no_we", 32'(bus.rf_we), 0); nxt;

        // Starvation
        for (int c = 0; c < 8; c++) begin
            setin(1, 21, 32'(c), 0, 0, 0, 1, 4, 32'h44);
            smp;
            chk("starve_no_stall", 32'(bus.stall_req), 0);
            nxt;
        end
        setin(0, 0, 0, 0, 0, 0, 1, 4, 32'h44);
        smp;
        chk("starve_stall", 32'(bus.stall_req), 1);
        chk("starve_dbg_ready", 32'(bus.dbg_ready), 1);
        chk("starve_dbg_addr", 32'(bus.rf_addr), 4);
        nxt;
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
        smp; chk("starve_cleared", 32'(bus.stall_req), 0); nxt;

        // Mixed directed pattern: kills, wrap, dead entries, dbg held until acked
        for (int i = 0; i < 60; i++) begin
            setin(!bus.stall_req && (i % 3 != 1), (i * 5) % 8, 32'(i) * 32'h1111,
                  (i % 4 != 3), (i * 3 + 1) % 8, 32'h1000 + 32'(i),
                  1'b1, int'(da), dd);
            smp;
            if (bus.dbg_ready) begin
                da = 5'((i * 7) % 8);
                dd = 32'hD000 + 32'(i);
            end
            nxt;
        end
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            smp; nxt;
        end
        smp;
        chk("end_pending", bus.pending, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
